// File: rtl/memdata_pkg.sv
// Shared definitions for the 8-bit data memory and its bus-master engine.
//   MEM_AW / MEM_DW / MEM_LW : default address, data and length widths
//   op_e    : command codes carried on memdata_dma.op
//   state_e : engine sequencing states
//   first_state() : state entered from IDLE for a freshly latched command
package memdata_pkg;

  localparam int MEM_AW = 12;
  localparam int MEM_DW = 8;
  localparam int MEM_LW = 12;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Block commands with a zero length skip straight to DONE without
  // touching memory; READ/WRITE ignore the length entirely.
  function automatic state_e first_state(input op_e op, input logic len_zero);
    state_e s;
    case (op)
      OP_READ:  s = ST_RD;
      OP_WRITE: s = ST_WR;
      OP_FILL:  s = len_zero ? ST_DONE : ST_WR;
      default:  s = len_zero ? ST_DONE : ST_RD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/memdata_dma.sv
// Bus-master engine for the memdata port. Executes one command at a time
// (READ, WRITE, FILL, COPY), drives cs/we/oe, address and write data, and
// reports completion with a single-cycle done pulse.
//   clk, reset_n          : clock, async active-low reset
//   start, op, src, dst,
//   len, wdata            : command, latched when start is seen in IDLE
//   abort                 : cancel the running command after the current access
//   rdata                 : registered READ result
//   busy, done            : command in progress / completion pulse
//   mem_cs/we/oe, mem_dir,
//   mem_indata            : memory strobes, address, write data (Moore-decoded)
//   mem_outdata           : memory read data
module memdata_dma
  import memdata_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] wdata,
  input  logic          abort,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          mem_cs,
  output logic          mem_we,
  output logic          mem_oe,
  output logic [AW-1:0] mem_dir,
  output logic [DW-1:0] mem_indata,
  input  logic [DW-1:0] mem_outdata
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] src_q, src_d;     // source pointer
  logic [AW-1:0] dst_q, dst_d;     // destination pointer
  logic [LW-1:0] cnt_q, cnt_d;     // words still to write
  logic [DW-1:0] wdata_q, wdata_d; // WRITE value / FILL pattern
  logic [DW-1:0] buf_q, buf_d;     // COPY word in flight
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          src_d   = src;
          dst_d   = dst;
          cnt_d   = len;
          wdata_d = wdata;
          state_d = first_state(op_e'(op), len == '0);
        end
      end

      ST_RD: begin
        // The read of this cycle always lands, even when aborting.
        if (op_q == OP_READ) rdata_d = mem_outdata;
        else                 buf_d   = mem_outdata;
        if (abort)                 state_d = ST_IDLE;
        else if (op_q == OP_READ)  state_d = ST_DONE;
        else                       state_d = ST_WR;
      end

      ST_WR: begin
        // Both pointers advance together so COPY stays word-aligned;
        // AW-bit arithmetic gives the wrap at the top of memory.
        cnt_d = cnt_q - LW'(1);
        src_d = src_q + AW'(1);
        dst_d = dst_q + AW'(1);
        if (abort)                                  state_d = ST_IDLE;
        else if (op_q == OP_WRITE || cnt_q == LW'(1)) state_d = ST_DONE;
        else if (op_q == OP_COPY)                   state_d = ST_RD;
        else                                        state_d = ST_WR;
      end

      default: state_d = ST_IDLE; // ST_DONE
    endcase
  end

  // Port decode depends on registered state only; idle values are zero.
  always_comb begin
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    mem_dir    = '0;
    mem_indata = '0;
    case (state_q)
      ST_RD: begin
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        mem_dir = src_q;
      end
      ST_WR: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_dir    = dst_q;
        mem_indata = (op_q == OP_COPY) ? buf_q : wdata_q;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_memdata_dma.sv
// Self-checking bench for memdata_dma: a memory array stands in for memdata,
// a transaction-level model expands every command into the expected per-cycle
// bus/status values, and one negedge process compares the DUT against them.
module tb_memdata_dma;
  import memdata_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [1:0]  op;
  logic [11:0] src, dst, len;
  logic [7:0]  wdata, rdata, mem_indata, mem_outdata;
  logic        busy, done, mem_cs, mem_we, mem_oe;
  logic [11:0] mem_dir;

  always #5 clk = ~clk;

  memdata_dma dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .wdata(wdata), .abort(abort), .rdata(rdata), .busy(busy),
    .done(done), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_dir(mem_dir), .mem_indata(mem_indata), .mem_outdata(mem_outdata)
  );

  // Physical memory seen by the DUT, plus a preload path for the bench.
  logic [7:0]  tb_mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;
  always @(posedge clk) begin
    if (pre_we)              tb_mem[pre_addr] <= pre_data;
    else if (mem_cs && mem_we) tb_mem[mem_dir] <= mem_indata;
  end
  assign mem_outdata = (mem_cs && mem_oe) ? tb_mem[mem_dir] : 8'h00;

  // Model state
  typedef struct packed {
    logic busy, done, cs, we, oe;
    logic [11:0] dir;
    logic [7:0]  indata;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl_mem [4096];
  logic [7:0] mdl_rdata = 8'h00;
  int         mdl_done  = 0;
  int         done_seen = 0;
  int         checks = 0, errors = 0;

  // Per-cycle compare: queued expectation while a command runs, idle otherwise.
  always @(negedge clk) begin
    exp_t e, act;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, mdl_rdata};
    act = {busy, done, mem_cs, mem_we, mem_oe, mem_dir, mem_indata, rdata};
    if (done) done_seen++;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL bus t=%0t act(busy,done,cs,we,oe,dir,wd,rd)=%b%b%b%b%b %h %h %h exp=%b%b%b%b%b %h %h %h",
               $time, act.busy, act.done, act.cs, act.we, act.oe, act.dir, act.indata, act.rdata,
               e.busy, e.done, e.cs, e.we, e.oe, e.dir, e.indata, e.rdata);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int a = 0; a < 4096; a++)
      if (bad < 0 && tb_mem[a] !== mdl_mem[a]) bad = a;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s addr=%h act=%h exp=%h", name, bad, tb_mem[bad], mdl_mem[bad]);
    end
  endtask

  task automatic push(input logic b, dn, c, w, o, input logic [11:0] a,
                      input logic [7:0] di, r);
    exp_t e;
    e = {b, dn, c, w, o, a, di, r};
    exp_q.push_back(e);
  endtask

  // Expand a command into the access list it must produce: READ/WRITE are one
  // access, FILL is len writes, COPY is len read/write pairs ascending. An
  // abort at access number abort_at ends the list there with no done.
  task automatic build(input logic [1:0] o, input logic [11:0] s, d, l,
                       input logic [7:0] w, input int abort_at, output int n);
    logic [7:0] rd, bufv;
    int acc, cnt;
    bit stop;
    rd = mdl_rdata; bufv = 8'h00; acc = 0; stop = 0;
    cnt = (o == OP_READ || o == OP_WRITE) ? 1 : int'(l);
    for (int i = 0; i < cnt && !stop; i++) begin
      logic [11:0] sa, da;
      sa = s + 12'(i);
      da = d + 12'(i);
      if (o == OP_READ || o == OP_COPY) begin
        push(1, 0, 1, 0, 1, sa, 8'h00, rd);
        acc++;
        if (o == OP_READ) rd = mdl_mem[sa];
        else              bufv = mdl_mem[sa];
        stop = (acc == abort_at);
      end
      if (!stop && o != OP_READ) begin
        logic [7:0] wv;
        wv = (o == OP_COPY) ? bufv : w;
        push(1, 0, 1, 1, 0, da, wv, rd);
        mdl_mem[da] = wv;
        acc++;
        stop = (acc == abort_at);
      end
    end
    if (!stop) begin
      push(1, 1, 0, 0, 0, 12'h000, 8'h00, rd);
      mdl_done++;
    end
    mdl_rdata = rd;
    n = exp_q.size();
  endtask

  // Issue one command; optionally abort at access abort_at, pulse a junk
  // start while busy, and hold abort together with the accepted start.
  task automatic run_cmd(input logic [1:0] o, input logic [11:0] s, d, l,
                         input logic [7:0] w, input int abort_at,
                         input bit garbage, input bit idle_abort, output int n);
    @(posedge clk); #1;
    start = 1'b1; op = o; src = s; dst = d; len = l; wdata = w; abort = idle_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    build(o, s, d, l, w, abort_at, n);
    // Scramble inputs: the engine must work from its latched copy.
    op = 2'($urandom); src = 12'($urandom); dst = 12'($urandom);
    len = 12'($urandom); wdata = 8'($urandom);
    start = garbage;
    abort = (abort_at == 1);
    for (int c = 2; c <= 300 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (c == abort_at);
    end
    abort = 1'b0;
    start = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout pending=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    pre_addr = a; pre_data = v; pre_we = 1'b1; mdl_mem[a] = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] save;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00;
    src = '0; dst = '0; len = '0; wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Fill memory with random contents while held in reset.
    for (int a = 0; a < 4096; a++) begin
      pre_addr = 12'(a); pre_data = 8'($urandom); mdl_mem[a] = pre_data; pre_we = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("reset_state", int'({busy, done, mem_cs, mem_we, mem_oe, mem_dir, mem_indata, rdata}), 0);

    // WRITE then READ back
    run_cmd(OP_WRITE, 12'h000, 12'h010, 12'h000, 8'hA5, 0, 0, 0, n);
    chk("write_cycles", n, 2);
    chk("write_mem", int'(tb_mem[12'h010]), 'hA5);
    run_cmd(OP_READ, 12'h010, 12'h000, 12'h000, 8'h00, 0, 0, 0, n);
    chk("read_cycles", n, 2);
    chk("read_rdata", int'(rdata), 'hA5);

    // FILL across the top-of-memory wrap
    save = tb_mem[12'h002];
    run_cmd(OP_FILL, 12'h000, 12'hFFE, 12'd4, 8'h3C, 0, 1, 0, n);
    chk("fill_cycles", n, 5);
    chk("fill_ffe", int'(tb_mem[12'hFFE]), 'h3C);
    chk("fill_fff", int'(tb_mem[12'hFFF]), 'h3C);
    chk("fill_000", int'(tb_mem[12'h000]), 'h3C);
    chk("fill_001", int'(tb_mem[12'h001]), 'h3C);
    chk("fill_002_untouched", int'(tb_mem[12'h002]), int'(save));

    // COPY of three preloaded words
    preload(12'h100, 8'h11); preload(12'h101, 8'h22); preload(12'h102, 8'h33);
    run_cmd(OP_COPY, 12'h100, 12'h200, 12'd3, 8'h00, 0, 1, 1, n);
    chk("copy_cycles", n, 7);
    chk("copy_200", int'(tb_mem[12'h200]), 'h11);
    chk("copy_201", int'(tb_mem[12'h201]), 'h22);
    chk("copy_202", int'(tb_mem[12'h202]), 'h33);

    // Zero-length FILL: done in cycle 1, no access
    run_cmd(OP_FILL, 12'h000, 12'h555, 12'd0, 8'hFF, 0, 0, 0, n);
    chk("fill0_cycles", n, 1);

    // COPY 8 aborted during its third write (access 6)
    save = tb_mem[12'h303];
    run_cmd(OP_COPY, 12'h380, 12'h300, 12'd8, 8'h00, 6, 1, 0, n);
    chk("abort_cycles", n, 6);
    for (int i = 0; i < 3; i++)
      chk("abort_copied", int'(tb_mem[12'h300 + 12'(i)]), int'(tb_mem[12'h380 + 12'(i)]));
    chk("abort_untouched", int'(tb_mem[12'h303]), int'(save));
    check_mem("mem_directed");

    // Reset in the 4th cycle of a FILL: three writes land, then everything clears.
    @(posedge clk); #1;
    start = 1'b1; op = OP_FILL; dst = 12'h7F0; len = 12'd10; wdata = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    build(OP_FILL, 12'h000, 12'h7F0, 12'd10, 8'h5A, 3, n);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    mdl_rdata = 8'h00;
    #1;
    chk("reset_async", int'({busy, done, mem_cs, mem_we, mem_oe, mem_dir, mem_indata, rdata}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_mem("mem_after_reset");
    run_cmd(OP_WRITE, 12'h000, 12'h7F5, 12'h000, 8'hC3, 0, 0, 0, n);
    run_cmd(OP_READ, 12'h7F5, 12'h000, 12'h000, 8'h00, 0, 0, 0, n);
    chk("post_reset_rdata", int'(rdata), 'hC3);

    // Randomized commands
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  ro;
      logic [11:0] rs, rdst, rl;
      int          ab;
      ro   = 2'($urandom_range(0, 3));
      rs   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4090, 4095)) : 12'($urandom);
      rdst = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4090, 4095)) : 12'($urandom);
      rl   = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 6)) : 12'($urandom);
      if (ro == OP_FILL || ro == OP_COPY) rl = 12'($urandom_range(0, 6));
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run_cmd(ro, rs, rdst, rl, 8'($urandom), ab, bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), n);
      check_mem("mem_random");
    end

    @(posedge clk); #1;
    chk("done_count", done_seen, mdl_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
